// File: rtl/fp_mul_pipe_param.sv
// fp_mul_pipe_param: pipelined floating-point multiplier with valid/ready flow
// control, round-to-nearest-even and {invalid, overflow, underflow} flags.
// Latency is MUL_STAGES+2 cycles; a single global stall freezes every stage.
// Optional macro FP_MUL_SPECIAL_EN enables NaN/infinity handling. When it is
// undefined, overflow saturates to the largest finite value.
module fp_mul_pipe_param #(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int MUL_STAGES = 2,
    parameter int TAG_W      = 31
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_p,
    output logic [TAG_W-1:0]       out_tag,
    output logic [2:0]             out_flags
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int PW  = 2 * MAN_W + 2;
    localparam int EW2 = EXP_W + 2;
    localparam logic        [EW2-1:0] BIAS = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0] ONE  = EW2'(1);
    localparam logic signed [EW2-1:0] ZERO = EW2'(0);
    localparam logic signed [EW2-1:0] EMAX = EW2'((1 << EXP_W) - 1);

    typedef struct packed {
        logic             sign;
        logic             zero;
        logic             nan;
        logic             inf;
        logic [EW2-1:0]   e;
        logic [TAG_W-1:0] tag;
    } meta_t;

    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // ---------------- stage 1: unpack ----------------
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_zero, b_zero, nan_c, inf_c;
    meta_t            m1_c;

    assign ea     = in_a[W-2 -: EXP_W];
    assign eb     = in_b[W-2 -: EXP_W];
    assign ma     = in_a[MAN_W-1:0];
    assign mb     = in_b[MAN_W-1:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);

`ifdef FP_MUL_SPECIAL_EN
    logic a_nan, b_nan, a_inf, b_inf;
    assign a_nan = (&ea) && (ma != '0);
    assign b_nan = (&eb) && (mb != '0);
    assign a_inf = (&ea) && (ma == '0);
    assign b_inf = (&eb) && (mb == '0);
    assign nan_c = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    assign inf_c = (a_inf || b_inf) && !nan_c;
`else
    assign nan_c = 1'b0;
    assign inf_c = 1'b0;
`endif

    // Operand metadata assembled for the stage-1 register
    always_comb begin
        m1_c      = '0;
        m1_c.sign = in_a[W-1] ^ in_b[W-1];
        m1_c.zero = a_zero || b_zero;
        m1_c.nan  = nan_c;
        m1_c.inf  = inf_c;
        m1_c.e    = EW2'(ea) + EW2'(eb) - BIAS;
        m1_c.tag  = in_tag;
    end

    logic             s1_v;
    meta_t            s1_m;
    logic [MAN_W:0]   s1_ma, s1_mb;

    // Stage 1 register: capture sign, exponent sum and mantissas with hidden bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s1_m  <= '0;
            s1_ma <= '0;
            s1_mb <= '0;
        end else if (!stall) begin
            s1_v  <= in_valid;
            s1_m  <= m1_c;
            s1_ma <= {1'b1, ma};
            s1_mb <= {1'b1, mb};
        end
    end

    // ---------------- multiplier stages ----------------
    logic          m_v [MUL_STAGES];
    meta_t         m_m [MUL_STAGES];
    logic [PW-1:0] m_p [MUL_STAGES];

    // Mantissa product in the first stage, then retimed through the rest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MUL_STAGES; i++) begin
                m_v[i] <= 1'b0;
                m_m[i] <= '0;
                m_p[i] <= '0;
            end
        end else if (!stall) begin
            m_v[0] <= s1_v;
            m_m[0] <= s1_m;
            m_p[0] <= {{(MAN_W+1){1'b0}}, s1_ma} * {{(MAN_W+1){1'b0}}, s1_mb};
            for (int unsigned i = 1; i < MUL_STAGES; i++) begin
                m_v[i] <= m_v[i-1];
                m_m[i] <= m_m[i-1];
                m_p[i] <= m_p[i-1];
            end
        end
    end

    // ---------------- final stage: normalise, round, pack ----------------
    logic [PW-1:0]           p_l, np;
    meta_t                   ml;
    logic [MAN_W-1:0]        mk;
    logic [MAN_W:0]          mr;
    logic                    g, st, up;
    logic signed [EW2-1:0]   ef;
    logic [W-1:0]            res_p;
    logic [2:0]              res_f;

    assign p_l = m_p[MUL_STAGES-1];
    assign ml  = m_m[MUL_STAGES-1];

    // Normalise so the leading one sits at PW-1, then round to nearest even
    always_comb begin
        np    = p_l[PW-1] ? p_l : (p_l << 1);
        mk    = np[PW-2 -: MAN_W];
        g     = np[PW-2-MAN_W];
        st    = |np[PW-3-MAN_W:0];
        up    = g && (st || mk[0]);
        mr    = {1'b0, mk} + {{MAN_W{1'b0}}, up};
        ef    = $signed(ml.e) + (p_l[PW-1] ? ONE : ZERO) + (mr[MAN_W] ? ONE : ZERO);
        res_p = {ml.sign, ef[EXP_W-1:0], mr[MAN_W-1:0]};
        res_f = 3'b000;
        if (ml.nan) begin
            res_p = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            res_f = 3'b100;
        end else if (ml.zero) begin
            res_p = {ml.sign, {(W-1){1'b0}}};
        end else if (ml.inf) begin
            res_p = {ml.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (ef >= EMAX) begin
`ifdef FP_MUL_SPECIAL_EN
            res_p = {ml.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
            res_p = {ml.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
            res_f = 3'b010;
        end else if (ef <= ZERO) begin
            res_p = {ml.sign, {(W-1){1'b0}}};
            res_f = 3'b001;
        end
    end

    // Output register: loads on advance, holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_p     <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else if (!stall) begin
            out_valid <= m_v[MUL_STAGES-1];
            if (m_v[MUL_STAGES-1]) begin
                out_p     <= res_p;
                out_tag   <= ml.tag;
                out_flags <= res_f;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe_param.sv
// Self-checking bench for fp_mul_pipe_param at default parameters.
// Expected values follow FP_MUL_SPECIAL_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_fp_mul_pipe_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0, in_b = '0;
    logic [30:0] in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_p;
    logic [30:0] out_tag;
    logic [2:0]  out_flags;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] p;
        logic [30:0] tag;
        logic [2:0]  f;
    } exp_t;
    exp_t sbq[$];

    localparam int NV = 10;
    logic [31:0] va [NV];
    logic [31:0] vb [NV];
    logic [31:0] vp [NV];
    logic [2:0]  vf [NV];

    always #5 clk = ~clk;

    fp_mul_pipe_param #(
        .EXP_W(8),
        .MAN_W(23),
        .MUL_STAGES(2),
        .TAG_W(31)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_tag(in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_p(out_p),
        .out_tag(out_tag),
        .out_flags(out_flags)
    );

    task load_vectors;
        va[0] = 32'h3FC00000; vb[0] = 32'h40000000; vp[0] = 32'h40400000; vf[0] = 3'b000;
        va[1] = 32'h3F800001; vb[1] = 32'h3FC00000; vp[1] = 32'h3FC00002; vf[1] = 3'b000;
        va[2] = 32'h3F800001; vb[2] = 32'h3F800001; vp[2] = 32'h3F800002; vf[2] = 3'b000;
        va[3] = 32'h00800000; vb[3] = 32'h3F000000; vp[3] = 32'h00000000; vf[3] = 3'b001;
        va[4] = 32'h80000000; vb[4] = 32'h3F800000; vp[4] = 32'h80000000; vf[4] = 3'b000;
        va[5] = 32'hC0000000; vb[5] = 32'h40400000; vp[5] = 32'hC0C00000; vf[5] = 3'b000;
        va[6] = 32'h7F000000; vb[6] = 32'h40000000;
        va[7] = 32'h7F800000; vb[7] = 32'h00000000;
        va[8] = 32'h7F800000; vb[8] = 32'h40000000;
        va[9] = 32'h7FC00000; vb[9] = 32'h3F800000;
`ifdef FP_MUL_SPECIAL_EN
        vp[6] = 32'h7F800000; vf[6] = 3'b010;
        vp[7] = 32'h7FC00000; vf[7] = 3'b100;
        vp[8] = 32'h7F800000; vf[8] = 3'b000;
        vp[9] = 32'h7FC00000; vf[9] = 3'b100;
`else
        vp[6] = 32'h7F7FFFFF; vf[6] = 3'b010;
        vp[7] = 32'h00000000; vf[7] = 3'b000;
        vp[8] = 32'h7F7FFFFF; vf[8] = 3'b010;
        vp[9] = 32'h7F7FFFFF; vf[9] = 3'b010;
`endif
    endtask

    task test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        checks++; if (out_p !== 32'h0) begin failures++; $display("FAIL reset_out_p got=%h want=0", out_p); end
        checks++; if (out_tag !== 31'h0) begin failures++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
        checks++; if (out_flags !== 3'b000) begin failures++; $display("FAIL reset_out_flags got=%b want=000", out_flags); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task test_directed;
        int lat;
        exp_t e;
        for (int k = 0; k < NV; k++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid = 1'b1; in_a = va[k]; in_b = vb[k];
            in_tag = (k == 0) ? 31'h5A : 31'(32'h200 + k);
            @(negedge clk);
            if (in_valid && in_ready) sbq.push_back({vp[k], in_tag, vf[k]});
            lat = 0;
            do begin
                @(posedge clk); #1 in_valid = 1'b0;
                @(negedge clk);
                lat++;
            end while (!out_valid && lat < 20);
            checks++;
            if (!out_valid) begin
                failures++; $display("FAIL dir%0d_timeout got=no_output want=output", k);
                sbq.delete();
            end else begin
                if (lat !== 4) begin failures++; $display("FAIL dir%0d_latency got=%0d want=4", k, lat); end
                if (sbq.size() == 0) begin
                    checks++; failures++; $display("FAIL dir%0d_unexpected got=output want=none", k);
                end else begin
                    e = sbq.pop_front();
                    checks++; if (out_p !== e.p) begin failures++; $display("FAIL dir%0d_p got=%h want=%h", k, out_p, e.p); end
                    checks++; if (out_tag !== e.tag) begin failures++; $display("FAIL dir%0d_tag got=%h want=%h", k, out_tag, e.tag); end
                    checks++; if (out_flags !== e.f) begin failures++; $display("FAIL dir%0d_flags got=%b want=%b", k, out_flags, e.f); end
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task test_back_to_back;
        int sent, recv, cyc, k;
        logic stall_cyc;
        exp_t e;
        sent = 0; recv = 0; cyc = 0;
        sbq.delete();
        while (recv < 8 && cyc < 60) begin
            @(posedge clk); #1;
            stall_cyc = (cyc >= 6 && cyc <= 8);
            out_ready = !stall_cyc;
            in_valid = (sent < 8);
            k = sent % NV;
            in_a = va[k]; in_b = vb[k]; in_tag = 31'(32'h100 + sent);
            @(negedge clk);
            checks++; if (in_ready !== !stall_cyc) begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%0b want=%0b", cyc, in_ready, !stall_cyc); end
            if (stall_cyc && out_valid && sbq.size() > 0) begin
                checks++; if (out_p !== sbq[0].p) begin failures++; $display("FAIL b2b_hold_p cyc=%0d got=%h want=%h", cyc, out_p, sbq[0].p); end
                checks++; if (out_tag !== sbq[0].tag) begin failures++; $display("FAIL b2b_hold_tag cyc=%0d got=%h want=%h", cyc, out_tag, sbq[0].tag); end
            end
            if (in_valid && in_ready) begin
                sbq.push_back({vp[k], in_tag, vf[k]});
                sent++;
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++; failures++; $display("FAIL b2b_unexpected got=%h want=none", out_p);
                end else begin
                    e = sbq.pop_front();
                    checks++; if (out_p !== e.p) begin failures++; $display("FAIL b2b_p n=%0d got=%h want=%h", recv, out_p, e.p); end
                    checks++; if (out_tag !== e.tag) begin failures++; $display("FAIL b2b_tag n=%0d got=%h want=%h", recv, out_tag, e.tag); end
                    checks++; if (out_flags !== e.f) begin failures++; $display("FAIL b2b_flags n=%0d got=%b want=%b", recv, out_flags, e.f); end
                end
                recv++;
            end
            cyc++;
        end
        checks++; if (recv !== 8) begin failures++; $display("FAIL b2b_count got=%0d want=8", recv); end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task test_reset_inflight;
        int n;
        sbq.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_a = va[0]; in_b = vb[0]; in_tag = 31'(32'h70 + i);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%0b want=1", out_valid); end
        rst_n = 1'b0; #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%0b want=0", out_valid); end
        checks++; if (out_p !== 32'h0) begin failures++; $display("FAIL rst_async_p got=%h want=0", out_p); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_async_in_ready got=%0b want=1", in_ready); end
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        checks++; if (n !== 0) begin failures++; $display("FAIL rst_stale_outputs got=%0d want=0", n); end
    endtask

    initial begin
        load_vectors();
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_mul_pipe_param.md
# fp_mul_pipe_param

Parametrised, fully pipelined IEEE-754-style floating-point multiplier with valid/ready flow control, round-to-nearest-even and exception flags. Sits in the inverse-square-root datapath wherever a full product is needed, including the Newton-iteration multiplies. It carries a sideband tag through the pipe for downstream operand alignment. Exponent and mantissa widths and the multiplier pipeline depth are parameters.

## Interface
- `EXP_W`, 8, exponent width; bias = 2^(EXP_W-1)-1.
- `MAN_W`, 23, stored mantissa width (hidden bit implicit).
- `MUL_STAGES`, 2, register stages in the mantissa multiplier, legal range 1..4.
- `TAG_W`, 31, sideband width passed unmodified alongside the operands.
- Derived width: `W = 1+EXP_W+MAN_W`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands this cycle.
- `in_a`, `in_b`  in  W  operands {sign, exp, mantissa}.
- `in_tag`  in  TAG_W  sideband.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_p`  out  W  product.
- `out_tag`  out  TAG_W  tag captured with the operands.
- `out_flags`  out  3  {invalid, overflow, underflow}.

## Operation
- An input is accepted when `in_valid && in_ready`. An output is consumed when `out_valid && out_ready`.
- Pipeline has LAT = MUL_STAGES+2 stages:
  - Stage 1: unpack, sign xor, exponent sum.
  - Stages 2..MUL_STAGES+1: mantissa product.
  - Final stage: normalise, round, pack, flag.
- Each stage carries its own valid bit.
- Global stall: `stall = out_valid && !out_ready`; `in_ready = !stall`. While stalled, every stage register holds its value. Bubbles are not compressed.
- Sign: `sa ^ sb`.
- Zero and denormal inputs: exp == 0 is treated as zero. The result is signed zero, no flags.
- Exponent: `e = ea + eb - bias`, computed signed in EXP_W+2 bits.
- Product `P = {1,ma} * {1,mb}`, 2*MAN_W+2 bits:
  - If the MSB of P is set, shift right 1 and `e = e+1`.
  - The kept mantissa is MAN_W bits below the leading 1.
- Rounding is round-to-nearest-even using guard bit G, sticky S (OR of the remaining bits) and mantissa LSB L. Round up iff `G && (S || L)`.
- A carry-out from rounding sets the mantissa to 0 and `e = e+1`.
- Overflow (`e >= 2^EXP_W-1`): overflow flag set; result as defined under Configuration.
- Underflow (`e <= 0`, non-zero operands): result is signed zero, underflow flag set. There is no denormal output.
- Reset: all stage valids clear, so `out_valid` = 0. `out_p`, `out_tag` and `out_flags` reset to 0; `in_ready` = 1 after reset.
- Reset mid-operation discards all in-flight items. Nothing is emitted afterwards for them.

## Timing
- Latency from acceptance to `out_valid` is LAT cycles when not stalled (4 at defaults).
- Throughput is 1 result per cycle with `out_ready` held high.
- Outputs are registered. `out_p`, `out_tag` and `out_flags` stay stable while `out_valid && !out_ready`.
- `in_ready` is combinational from `out_valid` and `out_ready` only.
- If accept and consume occur in the same cycle at full occupancy, both happen and the pipe advances.

## Configuration
- `FP_MUL_SPECIAL_EN` defined:
  - An operand with exp all-ones and non-zero mantissa is NaN.
  - NaN input, or inf × zero, gives canonical qNaN: sign 0, exp all-ones, mantissa MSB 1, rest 0. Invalid flag set.
  - inf × finite non-zero gives signed infinity, no flags.
  - Overflow gives signed infinity.
- `FP_MUL_SPECIAL_EN` undefined:
  - exp all-ones is an ordinary exponent.
  - Overflow saturates to signed max finite (exp = 2^EXP_W-2, mantissa all-ones).
  - The invalid flag is tied to 0.

## Test plan
- Defaults: 0x3FC00000 × 0x40000000 with tag 0x5A → after 4 cycles `out_p` = 0x40400000, `out_tag` = 0x5A, flags = 000.
- Tie-to-even: 0x3F800001 × 0x3FC00000 → 0x3FC00002. Also 0x3F800001 × 0x3F800001 → 0x3F800002.
- Overflow: 0x7F000000 × 0x40000000 → overflow flag set; 0x7F800000 with the macro, 0x7F7FFFFF without.
- Underflow and zero:
  - 0x00800000 × 0x3F000000 → 0x00000000 with underflow flag.
  - 0x80000000 × 0x3F800000 → 0x80000000 with no flags.
- Backpressure: stream 8 back-to-back products, drop `out_ready` for 3 cycles mid-stream → `in_ready` low exactly those cycles, held output stable, all 8 results in order with matching tags.
- Special values (macro on): 0x7F800000 × 0x00000000 → 0x7FC00000 with invalid flag. Assert `rst_n` with 3 items in flight → `out_valid` = 0 immediately and no stale results afterwards.
